// File: rtl/lsu_timeout_if.sv
// Memory-controller channel between an LSU and the memory arbiter.
// One valid/ready read path and one valid/ready write path.
interface lsu_timeout_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data,
        output mem_write_valid,
        output mem_write_address,
        output mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data,
        input  mem_write_valid,
        input  mem_write_address,
        input  mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/lsu_timeout.sv
// Per-thread load/store unit with a watchdog on the memory channel.
// Tracks the scheduler state and reports IDLE/REQUESTING/WAITING/DONE.
module lsu_timeout #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [3:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    lsu_timeout_if.master        mem,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);
    localparam logic [3:0] REQUEST = 4'b0100;
    localparam logic [3:0] UPDATE  = 4'b0111;

    // Counter is kept at least one bit wide so a disabled watchdog still elaborates.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        REQUESTING = 2'b01,
        WAITING    = 2'b10,
        DONE       = 2'b11
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_read;
    logic          hit;
    logic          expire;

    assign lsu_state = state;
    assign hit       = is_read ? mem.mem_read_ready : mem.mem_write_ready;
    assign expire    = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                 <= IDLE;
            cnt                   <= '0;
            is_read               <= 1'b0;
            mem.mem_read_valid    <= 1'b0;
            mem.mem_read_address  <= '0;
            mem.mem_write_valid   <= 1'b0;
            mem.mem_write_address <= '0;
            mem.mem_write_data    <= '0;
            lsu_out               <= '0;
            lsu_error             <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable && core_state == REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        is_read   <= decoded_mem_read_enable;
                        lsu_error <= 1'b0;
                        state     <= REQUESTING;
                    end
                end
                REQUESTING: begin
                    if (is_read) begin
                        mem.mem_read_valid   <= 1'b1;
                        mem.mem_read_address <= rs[ADDR_BITS-1:0];
                    end else begin
                        mem.mem_write_valid   <= 1'b1;
                        mem.mem_write_address <= rs[ADDR_BITS-1:0];
                        mem.mem_write_data    <= rt;
                    end
                    cnt   <= '0;
                    state <= WAITING;
                end
                WAITING: begin
                    // A response on the final cycle beats the watchdog.
                    if (hit) begin
                        if (is_read) begin
                            lsu_out            <= mem.mem_read_data;
                            mem.mem_read_valid <= 1'b0;
                        end else begin
                            mem.mem_write_valid <= 1'b0;
                        end
                        state <= DONE;
                    end else if (expire) begin
                        mem.mem_read_valid  <= 1'b0;
                        mem.mem_write_valid <= 1'b0;
                        lsu_error           <= 1'b1;
                        if (is_read) lsu_out <= '0;
                        state <= DONE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (core_state == UPDATE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_timeout.sv
// Randomised self-checking bench for lsu_timeout.
// Reference model predicts outcomes from response delay vs watchdog limit.
module tb_lsu_timeout;
    localparam int T = 4;
    localparam logic [3:0] REQ   = 4'b0100;
    localparam logic [3:0] UPD   = 4'b0111;
    localparam logic [3:0] WAITS = 4'b0101;

    typedef logic [1:0] seq_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] core_state;
    logic       rd, wr;
    logic [7:0] rs, rt;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    lsu_timeout_if #(.ADDR_BITS(8), .DATA_BITS(8)) mem ();

    lsu_timeout #(
        .ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .core_state(core_state),
        .decoded_mem_read_enable(rd),
        .decoded_mem_write_enable(wr),
        .rs(rs),
        .rt(rt),
        .mem(mem.master),
        .lsu_state(lsu_state),
        .lsu_out(lsu_out),
        .lsu_error(lsu_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    seq_t       seq;
    int         rv_cnt, wv_cnt;
    logic [7:0] raddr, waddr, wdata_obs;
    logic       err_at_req, early_valid;
    logic [7:0] exp_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Expected state trace: IDLE, REQUESTING, WAITING per waited cycle, DONE, IDLE.
    function automatic string exp_seq_str(int d);
        string s;
        s = "01";
        for (int i = 0; i < min_i(d, T); i++) s = {s, "2"};
        s = {s, "30"};
        return s;
    endfunction

    function automatic string seq_str(seq_t q);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%0d", q[i])};
        return s;
    endfunction

    task automatic run_txn(input logic r, input logic w, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] md,
                           input int delay, input bit noise, input bit hold);
        seq.delete();
        rv_cnt = 0;
        wv_cnt = 0;
        raddr = 8'h00;
        waddr = 8'h00;
        wdata_obs = 8'h00;
        seq.push_back(lsu_state);
        enable = 1'b1;
        core_state = REQ;
        rd = r;
        wr = w;
        rs = a;
        rt = d;
        mem.mem_read_data = md;
        tick();
        seq.push_back(lsu_state);
        err_at_req = lsu_error;
        early_valid = mem.mem_read_valid | mem.mem_write_valid;
        if (!hold) core_state = WAITS;
        enable = 1'($urandom_range(0, 1));
        tick();
        for (int k = 1; k <= T + 3; k++) begin
            seq.push_back(lsu_state);
            if (mem.mem_read_valid) begin
                rv_cnt++;
                raddr = mem.mem_read_address;
            end
            if (mem.mem_write_valid) begin
                wv_cnt++;
                waddr = mem.mem_write_address;
                wdata_obs = mem.mem_write_data;
            end
            if (lsu_state == 2'b11) break;
            if (k == 1) begin
                rs = 8'($urandom);
                rt = 8'($urandom);
                rd = 1'($urandom);
                wr = 1'($urandom);
            end
            mem.mem_read_ready  = r ? (k == delay) : noise;
            mem.mem_write_ready = r ? noise : (k == delay);
            tick();
        end
        mem.mem_read_ready = 1'b0;
        mem.mem_write_ready = 1'b0;
        core_state = UPD;
        tick();
        seq.push_back(lsu_state);
        core_state = 4'h0;
        enable = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        tests++;
        if (lsu_state !== 2'b00) begin
            fails++;
            $display("FAIL reset_state: got %b want 00", lsu_state);
        end
        tests++;
        if ({lsu_out, lsu_error} !== 9'h0) begin
            fails++;
            $display("FAIL reset_out: got out=%h err=%b want 0", lsu_out, lsu_error);
        end
        tests++;
        if ({mem.mem_read_valid, mem.mem_write_valid,
             mem.mem_read_address, mem.mem_write_address,
             mem.mem_write_data} !== 26'h0) begin
            fails++;
            $display("FAIL reset_bus: got rv=%b wv=%b want 0",
                     mem.mem_read_valid, mem.mem_write_valid);
        end
        reset = 1'b1;
        tick();
        exp_out = 8'h00;
    endtask

    task automatic test_load();
        run_txn(1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C, 3, 1'b0, 1'b0);
        exp_out = 8'h5C;
        tests++;
        if (seq_str(seq) != "0122230") begin
            fails++;
            $display("FAIL load_seq: got %s want 0122230", seq_str(seq));
        end
        tests++;
        if (raddr !== 8'h2A || rv_cnt != 3 || wv_cnt != 0 || early_valid !== 1'b0) begin
            fails++;
            $display("FAIL load_bus: got addr=%h rv=%0d wv=%0d early=%b want 2a 3 0 0",
                     raddr, rv_cnt, wv_cnt, early_valid);
        end
        tests++;
        if (lsu_out !== 8'h5C || lsu_error !== 1'b0) begin
            fails++;
            $display("FAIL load_out: got %h/%b want 5c/0", lsu_out, lsu_error);
        end
    endtask

    task automatic test_store();
        run_txn(1'b0, 1'b1, 8'h10, 8'hA5, 8'hEE, 1, 1'b0, 1'b0);
        tests++;
        if (wv_cnt != 1 || waddr !== 8'h10 || wdata_obs !== 8'hA5 || rv_cnt != 0) begin
            fails++;
            $display("FAIL store_bus: got wv=%0d addr=%h data=%h rv=%0d want 1 10 a5 0",
                     wv_cnt, waddr, wdata_obs, rv_cnt);
        end
        tests++;
        if (lsu_out !== exp_out || lsu_error !== 1'b0) begin
            fails++;
            $display("FAIL store_out: got %h/%b want %h/0", lsu_out, lsu_error, exp_out);
        end
        tests++;
        if (seq_str(seq) != exp_seq_str(1)) begin
            fails++;
            $display("FAIL store_seq: got %s want %s", seq_str(seq), exp_seq_str(1));
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 1'b0, 8'h33, 8'h00, 8'h99, 1000, 1'b0, 1'b0);
        exp_out = 8'h00;
        tests++;
        if (rv_cnt != T || seq_str(seq) != exp_seq_str(1000)) begin
            fails++;
            $display("FAIL timeout_seq: got rv=%0d seq=%s want %0d %s",
                     rv_cnt, seq_str(seq), T, exp_seq_str(1000));
        end
        tests++;
        if (lsu_error !== 1'b1 || lsu_out !== 8'h00) begin
            fails++;
            $display("FAIL timeout_out: got %h/%b want 00/1", lsu_out, lsu_error);
        end
        run_txn(1'b1, 1'b0, 8'h34, 8'h00, 8'h3C, 2, 1'b0, 1'b0);
        exp_out = 8'h3C;
        tests++;
        if (err_at_req !== 1'b0 || lsu_error !== 1'b0 || lsu_out !== 8'h3C) begin
            fails++;
            $display("FAIL error_clear: got req_err=%b err=%b out=%h want 0 0 3c",
                     err_at_req, lsu_error, lsu_out);
        end
    endtask

    task automatic test_boundary();
        run_txn(1'b1, 1'b0, 8'h55, 8'h00, 8'h77, T, 1'b0, 1'b0);
        exp_out = 8'h77;
        tests++;
        if (lsu_out !== 8'h77 || lsu_error !== 1'b0 || rv_cnt != T) begin
            fails++;
            $display("FAIL boundary_ready: got %h/%b rv=%0d want 77/0 %0d",
                     lsu_out, lsu_error, rv_cnt, T);
        end
        run_txn(1'b0, 1'b1, 8'h56, 8'h12, 8'h00, T + 1, 1'b0, 1'b0);
        tests++;
        if (lsu_out !== 8'h77 || lsu_error !== 1'b1 || wv_cnt != T) begin
            fails++;
            $display("FAIL boundary_wr_timeout: got %h/%b wv=%0d want 77/1 %0d",
                     lsu_out, lsu_error, wv_cnt, T);
        end
    endtask

    task automatic test_ignore();
        int busy;
        busy = 0;
        core_state = REQ;
        rs = 8'h44;
        for (int i = 0; i < 6; i++) begin
            enable = (i >= 3);
            rd = (i < 3);
            wr = 1'b0;
            tick();
            if (lsu_state !== 2'b00 || mem.mem_read_valid || mem.mem_write_valid) busy++;
        end
        core_state = 4'h0;
        enable = 1'b0;
        rd = 1'b0;
        tests++;
        if (busy != 0) begin
            fails++;
            $display("FAIL ignore_idle: got %0d busy cycles want 0", busy);
        end
        run_txn(1'b1, 1'b1, 8'h61, 8'hFF, 8'h62, 2, 1'b0, 1'b1);
        exp_out = 8'h62;
        tests++;
        if (wv_cnt != 0 || rv_cnt != 2 || raddr !== 8'h61 || lsu_out !== 8'h62) begin
            fails++;
            $display("FAIL both_set: got wv=%0d rv=%0d addr=%h out=%h want 0 2 61 62",
                     wv_cnt, rv_cnt, raddr, lsu_out);
        end
    endtask

    task automatic test_midreset();
        int late;
        late = 0;
        enable = 1'b1;
        core_state = REQ;
        rd = 1'b1;
        rs = 8'h4D;
        tick();
        core_state = WAITS;
        tick();
        tick();
        tests++;
        if (mem.mem_read_valid !== 1'b1 || lsu_state !== 2'b10) begin
            fails++;
            $display("FAIL midreset_pre: got rv=%b st=%b want 1 10",
                     mem.mem_read_valid, lsu_state);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_out = 8'h00;
        tests++;
        if ({lsu_state, lsu_out, lsu_error, mem.mem_read_valid,
             mem.mem_read_address} !== 20'h0) begin
            fails++;
            $display("FAIL midreset_clear: got st=%b out=%h err=%b rv=%b want 0",
                     lsu_state, lsu_out, lsu_error, mem.mem_read_valid);
        end
        core_state = 4'h0;
        enable = 1'b0;
        rd = 1'b0;
        mem.mem_read_ready = 1'b1;
        mem.mem_read_data = 8'hBB;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (lsu_state !== 2'b00 || lsu_out !== 8'h00) late++;
        end
        mem.mem_read_ready = 1'b0;
        tests++;
        if (late != 0) begin
            fails++;
            $display("FAIL midreset_late_ready: got %0d bad cycles want 0", late);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic       r, w, ok, exp_err;
            logic [7:0] a, d, md;
            int         dl, vc;
            r  = 1'($urandom);
            w  = r ? 1'($urandom) : 1'b1;
            a  = 8'($urandom);
            d  = 8'($urandom);
            md = 8'($urandom);
            dl = $urandom_range(1, T + 2);
            run_txn(r, w, a, d, md, dl, 1'($urandom), 1'($urandom));
            ok = (dl <= T);
            exp_err = !ok;
            if (r) exp_out = ok ? md : 8'h00;
            vc = min_i(dl, T);
            tests++;
            if (lsu_out !== exp_out || lsu_error !== exp_err) begin
                fails++;
                $display("FAIL rand_out[%0d]: got %h/%b want %h/%b",
                         n, lsu_out, lsu_error, exp_out, exp_err);
            end
            tests++;
            if (rv_cnt != (r ? vc : 0) || wv_cnt != (r ? 0 : vc)) begin
                fails++;
                $display("FAIL rand_valid[%0d]: got rv=%0d wv=%0d want read=%b cycles=%0d",
                         n, rv_cnt, wv_cnt, r, vc);
            end
            tests++;
            if (r ? (raddr !== a) : (waddr !== a || wdata_obs !== d)) begin
                fails++;
                $display("FAIL rand_addr[%0d]: got ra=%h wa=%h wd=%h want a=%h d=%h",
                         n, raddr, waddr, wdata_obs, a, d);
            end
            tests++;
            if (seq_str(seq) != exp_seq_str(dl)) begin
                fails++;
                $display("FAIL rand_seq[%0d]: got %s want %s",
                         n, seq_str(seq), exp_seq_str(dl));
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        core_state = 4'h0;
        rd = 1'b0;
        wr = 1'b0;
        rs = 8'h00;
        rt = 8'h00;
        mem.mem_read_ready = 1'b0;
        mem.mem_read_data = 8'h00;
        mem.mem_write_ready = 1'b0;
        exp_out = 8'h00;
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_boundary();
        test_ignore();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsu_timeout.md
Name: lsu_timeout

Overview:
- Per-thread load/store unit; the responder to the core scheduler's state machine.
- Follows the 4-bit core_state and reports its own 2-bit lsu_state back, which the scheduler polls in WAIT.
- Issues one read or write per instruction to the memory-controller valid/ready channel.
- A watchdog ensures a stalled memory channel can never hang the core.

Parameters:
- ADDR_BITS, 8, memory address width; must be <= DATA_BITS.
- DATA_BITS, 8, data and register width.
- TIMEOUT_CYCLES, 64, maximum WAITING cycles before abort; 0 disables the watchdog.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous active-low reset (asserted when 0).
- enable  input  1  thread active in current block.
- core_state  input  4  scheduler state (REQUEST=4'b0100, UPDATE=4'b0111).
- decoded_mem_read_enable  input  1  LDR instruction.
- decoded_mem_write_enable  input  1  STR instruction.
- rs  input  DATA_BITS  address operand.
- rt  input  DATA_BITS  store data operand.
- mem_read_valid  output  1  read request.
- mem_read_address  output  ADDR_BITS  read address.
- mem_read_ready  input  1  read response valid.
- mem_read_data  input  DATA_BITS  read response data.
- mem_write_valid  output  1  write request.
- mem_write_address  output  ADDR_BITS  write address.
- mem_write_data  output  DATA_BITS  write data.
- mem_write_ready  input  1  write acknowledged.
- lsu_state  output  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
- lsu_out  output  DATA_BITS  loaded data.
- lsu_error  output  1  last access timed out.

Behaviour:
- Reset (reset==0 at an edge): all outputs 0, lsu_state=IDLE, watchdog counter 0. This applies mid-transaction too: a valid is dropped at that same edge, and any late ready is ignored.
- IDLE -> REQUESTING: at an edge with enable=1, core_state==REQUEST, and read or write enable set. The operation type is latched at this edge. lsu_error clears at this edge.
- Read/write both set: treated as a read; the write is ignored.
- enable=0: the unit stays in IDLE. enable is ignored once the unit has left IDLE.
- REQUESTING (exactly one cycle), at the next edge:
  - read: mem_read_valid<=1, mem_read_address<=rs[ADDR_BITS-1:0].
  - write: mem_write_valid<=1, mem_write_address<=rs[ADDR_BITS-1:0], mem_write_data<=rt.
  - Then -> WAITING, counter<=0.
  - Any ready seen in REQUESTING is ignored.
- WAITING: address and data are held stable while valid=1. At each edge:
  - read with mem_read_ready=1: lsu_out<=mem_read_data, mem_read_valid<=0, -> DONE.
  - write with mem_write_ready=1: mem_write_valid<=0, -> DONE; lsu_out unchanged.
  - Otherwise, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: drop valid, lsu_error<=1, lsu_out<=0 (read only), -> DONE.
  - Otherwise counter<=counter+1. The counter is $clog2(TIMEOUT_CYCLES+1) bits and never wraps.
  - Ready and timeout on the same edge: ready wins and no error is raised. A ready is therefore accepted on WAITING cycles 1..TIMEOUT_CYCLES.
  - Ready on the opposite channel is ignored.
- DONE: the unit holds until an edge with core_state==UPDATE, then -> IDLE. lsu_out and lsu_error persist into IDLE.
- A core_state of REQUEST while the unit is not in IDLE is ignored; only one outstanding request is allowed.
- Latency with an immediate memory response: REQUEST edge -> valid visible 2 cycles later -> DONE the edge after ready.

Test Plan:
- Load, rs=8'h2A, mem_read_data=8'h5C, ready 3 cycles after valid -> mem_read_address=8'h2A, lsu_state sequence 00,01,10,10,10,11; lsu_out=8'h5C; lsu_error=0; returns to 00 at UPDATE.
- Store, rs=8'h10, rt=8'hA5, ready after 1 cycle -> mem_write_valid=1 for exactly 1 cycle with address 8'h10 and data 8'hA5; lsu_out unchanged; DONE then IDLE at UPDATE.
- TIMEOUT_CYCLES=4, read, ready never asserted -> valid high 4 cycles then dropped; lsu_state=11; lsu_error=1; lsu_out=0; the next load clears lsu_error on leaving IDLE.
- TIMEOUT_CYCLES=4, ready on WAITING cycle 4 with data 8'h77 -> accepted: lsu_out=8'h77, lsu_error=0.
- enable=0, or neither read nor write set, during REQUEST -> lsu_state stays 00 and no valid is asserted. Both read and write set -> a read only, mem_write_valid stays 0.
- reset=0 for one cycle while WAITING with valid=1 -> next cycle: all outputs 0, lsu_state=00; a ready arriving afterwards is ignored.
